// File: rtl/keycode_sequencer.sv
// keycode_sequencer: replays a fixed 12-key cheat sequence on the game keycode bus, paced by frame ticks
module keycode_sequencer #(
  parameter int HOLD_FRAMES = 2,
  parameter int GAP_FRAMES  = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       game_frame_clk_rising_edge,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] keycode_in,
  output logic [7:0] keycode_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);
  typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic [7:0] key;
  function automatic logic [7:0] key_at(input logic [3:0] i);
    case (i)
      4'd0, 4'd1:   key_at = 8'd82;
      4'd2, 4'd3:   key_at = 8'd81;
      4'd4, 4'd6:   key_at = 8'd80;
      4'd5, 4'd7:   key_at = 8'd79;
      4'd8, 4'd10:  key_at = 8'd29;
      default:      key_at = 8'd27;
    endcase
  endfunction
  // live keyboard passes through whenever playback is not driving the bus
  assign keycode_out = busy ? key : keycode_in;
  // playback state machine; busy, done, step and the driven key are registered alongside the state
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      key   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          state <= PRESS;
          cnt   <= '0;
          step  <= '0;
          busy  <= 1'b1;
          key   <= key_at(4'd0);
        end
        PRESS: if (abort) begin
          state <= IDLE;
          cnt   <= '0;
          step  <= '0;
          busy  <= 1'b0;
        end else if (game_frame_clk_rising_edge) begin
          if (cnt == 4'(HOLD_FRAMES - 1)) begin
            state <= GAP;
            cnt   <= '0;
            key   <= '0;
          end else cnt <= cnt + 4'd1;
        end
        GAP: if (abort) begin
          state <= IDLE;
          cnt   <= '0;
          step  <= '0;
          busy  <= 1'b0;
        end else if (game_frame_clk_rising_edge) begin
          if (cnt == 4'(GAP_FRAMES - 1)) begin
            cnt <= '0;
            if (step == 4'd11) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PRESS;
              step  <= step + 4'd1;
              key   <= key_at(step + 4'd1);
            end
          end else cnt <= cnt + 4'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          step  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keycode_sequencer.sv
// tb_keycode_sequencer: directed stimulus against a tick-counting playback model for two parameterisations
module tb_keycode_sequencer;
  localparam logic [7:0] TBL [12] = '{8'd82, 8'd82, 8'd81, 8'd81, 8'd80, 8'd79, 8'd80, 8'd79, 8'd29, 8'd27, 8'd29, 8'd27};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] kin;
  logic abort;
  logic [1:0] start_v, tick_v, busy, done;
  logic [1:0][7:0] ko;
  logic [1:0][3:0] st;
  int checks = 0, errors = 0;
  int tick_per, phase, n;
  int b0 = 0, d0 = 0, b1 = 0, d1 = 0, base0, bd;
  logic pat0;
  keycode_sequencer dut0 (
    .Clk(clk), .Reset(rst), .game_frame_clk_rising_edge(tick_v[0]), .start(start_v[0]), .abort(abort),
    .keycode_in(kin), .keycode_out(ko[0]), .busy(busy[0]), .done(done[0]), .step(st[0]));
  keycode_sequencer #(.HOLD_FRAMES(1), .GAP_FRAMES(1)) dut1 (
    .Clk(clk), .Reset(rst), .game_frame_clk_rising_edge(tick_v[1]), .start(start_v[1]), .abort(abort),
    .keycode_in(kin), .keycode_out(ko[1]), .busy(busy[1]), .done(done[1]), .step(st[1]));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int hold_of(input int i);
    return i == 0 ? 2 : 1;
  endfunction
  function automatic int per_of(input int i);
    return hold_of(i) + 1;
  endfunction
  // model: a playback is just the number of counted ticks since it began
  logic m_act [2];
  int   m_t   [2];
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] <= 1'b0;
        m_t[i]   <= 0;
      end else if (!m_act[i]) begin
        if (start_v[i] && !abort) begin
          m_act[i] <= 1'b1;
          m_t[i]   <= 0;
        end
      end else if (m_t[i] == 12 * per_of(i) || abort) m_act[i] <= 1'b0;
      else if (tick_v[i]) m_t[i] <= m_t[i] + 1;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int p, t, e_ko, e_step;
      p = per_of(i);
      t = m_t[i];
      e_ko = !m_act[i] ? int'(kin) : (t < 12 * p && t % p < hold_of(i)) ? int'(TBL[t / p]) : 0;
      e_step = !m_act[i] ? 0 : (t / p > 11 ? 11 : t / p);
      chk($sformatf("model_ko%0d", i), ko[i], e_ko);
      chk($sformatf("model_busy%0d", i), busy[i], m_act[i]);
      chk($sformatf("model_done%0d", i), done[i], m_act[i] && t == 12 * p);
      chk($sformatf("model_step%0d", i), st[i], e_step);
    end
    if (pat0 && busy[0]) begin
      int k;
      k = b0 - base0;
      chk("pattern0_ko", ko[0], k < 144 && k % 12 < 8 ? int'(TBL[k / 12]) : 0);
      chk("pattern0_done", done[0], k == 144);
    end
    if (busy[1]) begin
      chk("pattern1_ko", ko[1], b1 < 24 && b1 % 2 == 0 ? int'(TBL[b1 / 2]) : 0);
      chk("pattern1_done", done[1], b1 == 24);
    end
    if (busy[0]) b0++;
    if (done[0]) d0++;
    if (busy[1]) b1++;
    if (done[1]) d1++;
  end
  task automatic cyc(input logic s0, input logic s1, input logic a);
    @(posedge clk);
    #1;
    tick_v[0] = tick_per != 0 && phase % tick_per == 0;
    phase++;
    tick_v[1] = 1'b1;
    start_v = {s1, s0};
    abort = a;
  endtask
  task automatic wait_for(input string name, input int s, input logic gap);
    n = 0;
    while (!(st[0] == 4'(s) && busy[0] && ((ko[0] == 8'd0) == gap)) && n < 400) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk(name, n < 400, 1);
  endtask
  initial begin
    kin = 8'd44;
    abort = 1'b0;
    start_v = '0;
    tick_v = '0;
    tick_per = 0;
    phase = 0;
    pat0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ko", ko[0], 44);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_step", st[0], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_ko", ko[0], 44);
    chk("idle_busy", busy[0], 0);
    tick_per = 4;
    phase = 0;
    base0 = b0;
    bd = d0;
    pat0 = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("start_ko", ko[0], 82);
    repeat (160) cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_cycles", b0 - base0, 145);
    chk("done_pulses", d0 - bd, 1);
    pat0 = 1'b0;
    kin = 8'd17;
    phase = 0;
    bd = d0;
    cyc(1'b1, 1'b0, 1'b0);
    wait_for("wait_step5", 5, 1'b0);
    abort = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_busy", busy[0], 0);
    chk("abort_ko", ko[0], 17);
    chk("abort_step", st[0], 0);
    chk("abort_no_done", d0 - bd, 0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_wins", busy[0], 0);
    phase = 0;
    bd = d0;
    cyc(1'b1, 1'b0, 1'b0);
    wait_for("wait_step3", 3, 1'b0);
    start_v[0] = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    repeat (160) cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("restart_ignored_done", d0 - bd, 1);
    phase = 0;
    cyc(1'b1, 1'b0, 1'b0);
    wait_for("wait_gap9", 9, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", busy[0], 0);
    chk("async_done", done[0], 0);
    chk("async_step", st[0], 0);
    chk("async_ko", ko[0], 17);
    @(posedge clk);
    #1 rst = 1'b0;
    base0 = b0;
    repeat (100) cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_reset_busy", b0 - base0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (40) cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fast_busy_cycles", b1, 25);
    chk("fast_done_pulses", d1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keycode_sequencer.md
KEYCODE_SEQUENCER -- requirements
Module: keycode_sequencer

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
  HOLD_FRAMES  2  frame edges each key is held (legal 1..15)
  GAP_FRAMES   1  frame edges of keycode 0 after each key (legal 1..15)
REQ-002 SHALL provide ports, one per line: name  direction  width  meaning.
  Clk  in  1  system clock; all state on posedge
  Reset  in  1  asynchronous, active-high reset
  game_frame_clk_rising_edge  in  1  one-cycle frame tick
  start  in  1  request playback of the cheat sequence
  abort  in  1  cancel playback
  keycode_in  in  8  live keyboard keycode
  keycode_out  out  8  keycode bus presented to game logic
  busy  out  1  playback in progress
  done  out  1  one-cycle pulse when playback completes
  step  out  4  current sequence index 0..11

Function
REQ-003 SHALL emit the fixed 12-key table, in index order: 82,82,81,81,80,79,80,79,29,27,29,27 (UP UP DOWN DOWN LEFT RIGHT LEFT RIGHT Z X Z X).
REQ-004 SHALL implement states IDLE, PRESS, GAP, DONE.
REQ-005 IDLE: keycode_out = keycode_in combinationally; busy=0; step=0; frame counter=0.
REQ-006 IDLE: start=1 and abort=0 -> PRESS next cycle, step=0, frame counter=0.
REQ-007 PRESS: keycode_out = table[step]; busy=1.
REQ-008 PRESS: frame counter increments only on game_frame_clk_rising_edge; on a tick with counter == HOLD_FRAMES-1 -> GAP, counter cleared.
REQ-009 GAP: keycode_out = 8'd0; busy=1; counter increments on ticks only.
REQ-010 GAP: on a tick with counter == GAP_FRAMES-1 -> if step==11 then DONE, else step+1 and PRESS, counter cleared.
REQ-011 DONE: lasts exactly one cycle; done=1, keycode_out=0, busy=1; then IDLE.
REQ-012 done SHALL be 0 in every state other than DONE.
REQ-013 start SHALL be ignored outside IDLE; no queuing of a second request.
REQ-014 abort=1 in PRESS, GAP or DONE -> IDLE next cycle; done not asserted; step cleared.
REQ-015 start and abort both 1 in IDLE -> remain IDLE (abort wins).
REQ-016 keycode_in SHALL have no effect on keycode_out while busy=1.
REQ-017 Ticks arriving in the same cycle as entry into PRESS (start cycle) SHALL not count; counting begins the cycle after entry.
REQ-018 Counter width 4 bits; no wrap possible within legal parameter range.
REQ-019 Total playback, ticks every cycle: 12*(HOLD_FRAMES+GAP_FRAMES) cycles in PRESS/GAP plus 1 DONE cycle.

Reset
REQ-020 Reset=1 SHALL force IDLE asynchronously, step=0, counter=0, busy=0, done=0.
REQ-021 While Reset=1 keycode_out SHALL equal keycode_in.
REQ-022 Reset asserted mid-playback SHALL abandon the sequence with no done pulse; playback resumes only on a new start after release.

Verification
REQ-023 Defaults, ticks every 4 cycles, start pulse -> keycode_out shows 82 for 8 cycles, 0 for 4 cycles, 82 for 8, 0 for 4, ... through 27; done pulses once; 145 busy cycles total.
REQ-024 IDLE, keycode_in=44 -> keycode_out=44, busy=0; after start, keycode_in=44 -> keycode_out=82.
REQ-025 abort at step=5 during PRESS -> next cycle IDLE, keycode_out=keycode_in, done never 1, step=0.
REQ-026 start and abort same cycle in IDLE -> busy stays 0; start pulsed again at step=3 -> step sequence unaffected.
REQ-027 Reset asserted in GAP at step=9 -> outputs return to reset values immediately, without waiting for a Clk edge; after release with no start, busy stays 0 for 100 cycles.
REQ-028 HOLD_FRAMES=1, GAP_FRAMES=1, tick every cycle -> keycode_out alternates table[i],0 per cycle; DONE reached 24 cycles after PRESS entry.
